song_arbiter: RTL

//  Schedules the single piezo song player among three requesters: alarm, hourly chime and manual play.
//  It latches request pulses and grants the player to one requester at a time, by fixed priority.
//  It drives the player's song select and play enable, and times each playback in beats.
//  It sits between the clock/alarm logic and the song player.

---
 rtl/song_arbiter_if.sv | 21 ++
 rtl/song_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/song_arbiter_if.sv
// song_arbiter_if: request/control and player-side signals of the song arbiter
interface song_arbiter_if;
   logic       alarm_req;
   logic       chime_req;
   logic       manual_req;
   logic [1:0] manual_song;
   logic       stop;
   logic       play_en;
   logic [1:0] song_id;
   logic       busy;
   logic [1:0] active_src;
   logic       done;
   modport master (
      output alarm_req, chime_req, manual_req, manual_song, stop,
      input  play_en, song_id, busy, active_src, done
   );
   modport slave (
      input  alarm_req, chime_req, manual_req, manual_song, stop,
      output play_en, song_id, busy, active_src, done
   );
endinterface

// File: rtl/song_arbiter.sv
// song_arbiter: fixed-priority scheduler of the piezo song player (alarm > chime > manual)
module song_arbiter #(
   parameter int         BEAT_DIV   = 12_500_000,
   parameter int         SONG_BEATS = 64,
   parameter int         ALARM_REPS = 3,
   parameter int         GAP_BEATS  = 4,
   parameter logic [1:0] ALARM_SONG = 2'd0,
   parameter logic [1:0] CHIME_SONG = 2'd1
) (
   input logic          sys_CLK,
   input logic          rst_n,
   song_arbiter_if.slave bus
);
   localparam int DW = $clog2(BEAT_DIV + 1);
   localparam int BW = $clog2(SONG_BEATS + GAP_BEATS + 1);
   localparam int RW = $clog2(ALARM_REPS + 1);
   typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;
   state_t          state, state_n;
   logic            alarm_f, chime_f, manual_f;
   logic [1:0]      man_song, grant, song_sel;
   logic [DW-1:0]   div, div_n;
   logic [BW-1:0]   beats, beats_n;
   logic [RW-1:0]   reps, reps_n;
   logic            tick, play_n, busy_n, done_n;
   logic [1:0]      song_n, src_n;
   always_comb begin
      tick     = div == DW'(BEAT_DIV - 1);
      // only an alarm may take the player away from a running chime/manual song
      grant    = state == IDLE ? (alarm_f ? 2'd1 : chime_f ? 2'd2 : manual_f ? 2'd3 : 2'd0)
               : (state == PLAY && alarm_f && bus.active_src != 2'd1) ? 2'd1 : 2'd0;
      song_sel = grant == 2'd1 ? ALARM_SONG : grant == 2'd2 ? CHIME_SONG : man_song;
      state_n  = state;
      div_n    = tick ? '0 : div + DW'(1);
      beats_n  = beats + BW'(tick);
      reps_n   = reps;
      play_n   = bus.play_en;
      song_n   = bus.song_id;
      busy_n   = bus.busy;
      src_n    = bus.active_src;
      done_n   = 1'b0;
      if (bus.stop) begin
         state_n = IDLE;
         play_n  = 1'b0;
         busy_n  = 1'b0;
         src_n   = 2'd0;
         reps_n  = '0;
         div_n   = '0;
         beats_n = '0;
      end else if (grant != 2'd0) begin
         state_n = PLAY;
         play_n  = 1'b1;
         busy_n  = 1'b1;
         src_n   = grant;
         song_n  = song_sel;
         reps_n  = grant == 2'd1 ? RW'(ALARM_REPS - 1) : '0;
         div_n   = '0;
         beats_n = '0;
      end else if (state == PLAY && tick && beats == BW'(SONG_BEATS - 1)) begin
         state_n = reps != '0 ? GAP : IDLE;
         play_n  = 1'b0;
         busy_n  = reps != '0;
         src_n   = reps != '0 ? bus.active_src : 2'd0;
         done_n  = reps == '0;
         reps_n  = reps != '0 ? reps - RW'(1) : reps;
         div_n   = '0;
         beats_n = '0;
      end else if (state == GAP && tick && beats == BW'(GAP_BEATS - 1)) begin
         state_n = PLAY;
         play_n  = 1'b1;
         div_n   = '0;
         beats_n = '0;
      end else if (state == IDLE) begin
         div_n   = '0;
         beats_n = '0;
      end
   end
   always_ff @(posedge sys_CLK) begin
      if (!rst_n) begin
         state          <= IDLE;
         alarm_f        <= 1'b0;
         chime_f        <= 1'b0;
         manual_f       <= 1'b0;
         man_song       <= 2'd0;
         div            <= '0;
         beats          <= '0;
         reps           <= '0;
         bus.play_en    <= 1'b0;
         bus.song_id    <= 2'd0;
         bus.busy       <= 1'b0;
         bus.active_src <= 2'd0;
         bus.done       <= 1'b0;
      end else begin
         state          <= state_n;
         // a request in its own grant cycle keeps the flag set, so the song replays
         alarm_f        <= !bus.stop && (bus.alarm_req  || (alarm_f  && grant != 2'd1));
         chime_f        <= !bus.stop && (bus.chime_req  || (chime_f  && grant != 2'd2));
         manual_f       <= !bus.stop && (bus.manual_req || (manual_f && grant != 2'd3));
         if (!bus.stop && bus.manual_req) man_song <= bus.manual_song;
         div            <= div_n;
         beats          <= beats_n;
         reps           <= reps_n;
         bus.play_en    <= play_n;
         bus.song_id    <= song_n;
         bus.busy       <= busy_n;
         bus.active_src <= src_n;
         bus.done       <= done_n;
      end
   end
endmodule
